// File: rtl/async_pkg.sv
// Types shared by the clocked-to-asynchronous (WCHB) interface blocks.
package async_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    RTZ    = 2'd3
  } s2a_state_t;

endpackage

// File: rtl/s2a_bridge_if.sv
// Producer-side valid/ready bus plus the 4-phase bundled-data request/ack pair.
interface s2a_bridge_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              a_req;
  logic              a_ack;
  logic [DATA_W-1:0] a_data;
  logic              busy;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  s_valid, s_data, a_ack,
    output s_ready, a_req, a_data, busy, count
  );

  modport master (
    output s_valid, s_data, a_ack,
    input  s_ready, a_req, a_data, busy, count
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/s2a_bridge.sv
// Clocked valid/ready to 4-phase return-to-zero bundled-data bridge feeding a WCHB pipeline.
//
//   state  | meaning
//   IDLE   | no word in flight; pops the FIFO head into a_data when one is waiting
//   SETUP  | a_data loaded, a_req still low for one full clock of data setup
//   REQ_HI | a_req high, waiting for the synchronized ack to rise
//   RTZ    | a_req low, waiting for the synchronized ack to return to zero
module s2a_bridge
  import async_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  s2a_bridge_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_run;
  logic              r_a_req;
  logic [DATA_W-1:0] r_a_data;
  s2a_state_t        r_state;

  s2a_state_t        w_state_nxt;
  logic              w_a_req_nxt;
  logic              w_ack_sync;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_s_ready;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.a_ack),
    .o_q   (w_ack_sync)
  );

  // r_run keeps s_ready low until the first edge after reset release.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_s_ready = r_run & ~w_full;
  assign w_push    = bus.s_valid & w_s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_a_req_nxt = r_a_req;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_a_req_nxt = 1'b1;
        w_state_nxt = REQ_HI;
      end
      REQ_HI: begin
        if (w_ack_sync) begin
          w_a_req_nxt = 1'b0;
          w_state_nxt = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_sync) begin
          if (w_empty) begin
            w_state_nxt = IDLE;
          end else begin
            w_pop       = 1'b1;
            w_state_nxt = SETUP;
          end
        end
      end
      default: begin
        w_a_req_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_req  <= 1'b0;
      r_a_data <= '0;
      r_run    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_req <= w_a_req_nxt;
      r_run   <= 1'b1;
      if (w_pop) begin
        r_a_data <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reset clears the pointers and count, which discards it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.a_req   = r_a_req;
  assign bus.a_data  = r_a_data;
  assign bus.busy    = (r_state != IDLE);
  assign bus.count   = r_count;

endmodule
